// File: rtl/ex_sched_pkg.sv
// ex_sched_pkg: shared register-width default, MDU latency default and scheduler state encoding.
package ex_sched_pkg;
    localparam int W_RD_DEF    = 3;
    localparam int MDU_LAT_DEF = 4;
    localparam int W_CNT_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;
endpackage

// File: rtl/ex_sched_lat_cnt.sv
// lat_cnt: loadable down-counter that saturates at zero and flags when it gets there.
module lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;

    assign zero = cnt == '0;
endmodule

// File: rtl/ex_sched.sv
// ex_sched: issues single-cycle ops to EX and one multi-cycle op at a time to the MDU,
// guarding the in-flight MDU destination and arbitrating the shared writeback port.
module ex_sched
    import ex_sched_pkg::*;
#(
    parameter int W_RD    = W_RD_DEF,
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int W_CNT   = W_CNT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    input  logic            multi_i,
    input  logic [W_RD-1:0] src_num_i,
    input  logic [W_RD-1:0] rd_num_i,
    input  logic            stall_i,
    output logic            stall_o,
    output logic            ex_go_o,
    output logic            mdu_start_o,
    output logic            busy_o,
    output logic            wb_v_o,
    output logic            wb_sel_o,
    output logic [W_RD-1:0] wb_rd_num_o
);
    sched_state_t    state;
    logic [W_RD-1:0] pend_rd;
    logic            cnt_zero;
    logic            hazard;
    logic            mdu_acc;

    assign hazard      = (state != IDLE) && (src_num_i == pend_rd || rd_num_i == pend_rd);
    // Combinational handshakes are forced low while reset is asserted.
    assign ex_go_o     = rst && v_i && !multi_i && !stall_i && !hazard && state != DRAIN;
    assign mdu_acc     = rst && v_i && multi_i && !stall_i && state == IDLE;
    assign mdu_start_o = mdu_acc;
    assign stall_o     = rst && v_i && !(ex_go_o || mdu_acc);
    assign busy_o      = state != IDLE;

    lat_cnt #(.W(W_CNT)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (mdu_acc),
        .load_val (W_CNT'(MDU_LAT - 1)),
        .dec      (state == RUN),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pend_rd     <= '0;
            wb_v_o      <= 1'b0;
            wb_sel_o    <= 1'b0;
            wb_rd_num_o <= '0;
        end else begin
            case (state)
                IDLE:    if (mdu_acc) begin
                             state   <= RUN;
                             pend_rd <= rd_num_i;
                         end
                RUN:     if (cnt_zero) state <= DRAIN;
                DRAIN:   if (!stall_i) state <= IDLE;
                default: state <= IDLE;
            endcase
            // MDU result owns the writeback port whenever it is draining.
            if (state == DRAIN && !stall_i) begin
                wb_v_o      <= 1'b1;
                wb_sel_o    <= 1'b1;
                wb_rd_num_o <= pend_rd;
            end else if (ex_go_o) begin
                wb_v_o      <= 1'b1;
                wb_sel_o    <= 1'b0;
                wb_rd_num_o <= rd_num_i;
            end else if (!stall_i) begin
                wb_v_o      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex_sched.sv
// tb_ex_sched: directed checks of issue, hazard stalls, MDU timing, drain stalls and reset.
module tb_ex_sched;
    logic       clk = 1'b0, rst = 1'b0;
    logic       v_i = 1'b0, multi_i = 1'b0, stall_i = 1'b0;
    logic [2:0] src_num_i = '0, rd_num_i = '0;
    logic       stall_o, ex_go_o, mdu_start_o, busy_o, wb_v_o, wb_sel_o;
    logic [2:0] wb_rd_num_o;
    logic       stall_1, ex_go_1, mdu_start_1, busy_1, wb_v_1, wb_sel_1;
    logic [2:0] wb_rd_1;
    int         n_cmp = 0, n_err = 0;

    ex_sched dut (
        .clk(clk), .rst(rst), .v_i(v_i), .multi_i(multi_i), .src_num_i(src_num_i),
        .rd_num_i(rd_num_i), .stall_i(stall_i), .stall_o(stall_o), .ex_go_o(ex_go_o),
        .mdu_start_o(mdu_start_o), .busy_o(busy_o), .wb_v_o(wb_v_o), .wb_sel_o(wb_sel_o),
        .wb_rd_num_o(wb_rd_num_o)
    );

    ex_sched #(.MDU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .v_i(v_i), .multi_i(multi_i), .src_num_i(src_num_i),
        .rd_num_i(rd_num_i), .stall_i(stall_i), .stall_o(stall_1), .ex_go_o(ex_go_1),
        .mdu_start_o(mdu_start_1), .busy_o(busy_1), .wb_v_o(wb_v_1), .wb_sel_o(wb_sel_1),
        .wb_rd_num_o(wb_rd_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic [2:0] s, input logic [2:0] r);
        v_i = v; multi_i = m; src_num_i = s; rd_num_i = r;
        #1;
    endtask

    initial begin
        int b0, b1, t0, t1, ns, ms;
        logic [2:0] r0, r1;
        logic seen;
        #2;
        chk("rst_wb_v", wb_v_o, 0);
        chk("rst_wb_sel", wb_sel_o, 0);
        chk("rst_wb_rd", wb_rd_num_o, 0);
        chk("rst_busy", busy_o, 0);
        step; step;
        rst = 1'b1;

        drive(1, 0, 0, 2);
        chk("ex_go", ex_go_o, 1);
        chk("ex_nostall", stall_o, 0);
        chk("ex_nostart", mdu_start_o, 0);
        step; drive(0, 0, 0, 0);
        chk("ex_wb_v", wb_v_o, 1);
        chk("ex_wb_sel", wb_sel_o, 0);
        chk("ex_wb_rd", wb_rd_num_o, 2);
        step;
        chk("idle_wb_v", wb_v_o, 0);

        drive(1, 1, 0, 5);
        chk("mdu_start", mdu_start_o, 1);
        chk("mdu_nostall", stall_o, 0);
        b0 = 0; b1 = 0; t0 = 0; t1 = 0; ms = 0; r0 = '0; r1 = '0;
        for (int i = 1; i <= 6; i++) begin
            step;
            if (i == 1) drive(0, 0, 0, 0);
            b0 += int'(busy_o); b1 += int'(busy_1); ms += int'(mdu_start_o);
            if (wb_v_o && wb_sel_o) begin t0 = i; r0 = wb_rd_num_o; end
            if (wb_v_1 && wb_sel_1) begin t1 = i; r1 = wb_rd_1; end
        end
        chk("busy_cycles", b0, 5);
        chk("mdu_wb_edge", t0, 6);
        chk("mdu_wb_rd", r0, 5);
        chk("start_pulse", ms, 0);
        chk("lat1_busy", b1, 2);
        chk("lat1_wb_edge", t1, 3);
        chk("lat1_wb_rd", r1, 5);
        step;
        chk("post_wb_v", wb_v_o, 0);

        drive(1, 1, 0, 5);
        step; drive(1, 0, 5, 0);
        chk("src_haz_stall", stall_o, 1);
        chk("src_haz_nogo", ex_go_o, 0);
        step;
        chk("src_haz_hold", stall_o, 1);
        drive(1, 0, 1, 3);
        chk("nohaz_go", ex_go_o, 1);
        chk("nohaz_nostall", stall_o, 0);
        step;
        chk("run_ex_wb_v", wb_v_o, 1);
        chk("run_ex_wb_sel", wb_sel_o, 0);
        chk("run_ex_wb_rd", wb_rd_num_o, 3);
        drive(1, 1, 0, 6);
        chk("multi2_stall", stall_o, 1);
        chk("multi2_nostart", mdu_start_o, 0);
        ns = 0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (mdu_start_o) break;
            ns += int'(stall_o);
        end
        chk("multi2_start", mdu_start_o, 1);
        chk("multi2_stall_cyc", ns, 2);
        chk("multi2_go_stall", stall_o, 0);
        chk("drain_wb_v", wb_v_o, 1);
        chk("drain_wb_sel", wb_sel_o, 1);
        chk("drain_wb_rd", wb_rd_num_o, 5);

        step; drive(0, 0, 0, 0);
        step; drive(1, 0, 0, 6);
        chk("rd_haz_stall", stall_o, 1);
        step; drive(0, 0, 0, 0);
        chk("rd_haz_wb_v", wb_v_o, 0);
        step;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("dstall_busy", busy_o, 1);
            chk("dstall_wb_v", wb_v_o, 0);
            chk("dstall_wb_sel", wb_sel_o, 1);
            chk("dstall_wb_rd", wb_rd_num_o, 5);
        end
        stall_i = 1'b0;
        step;
        chk("dfree_wb_v", wb_v_o, 1);
        chk("dfree_wb_sel", wb_sel_o, 1);
        chk("dfree_wb_rd", wb_rd_num_o, 6);
        chk("dfree_busy", busy_o, 0);
        step;
        chk("dfree_after", wb_v_o, 0);

        drive(1, 1, 0, 7);
        step; drive(0, 0, 0, 0);
        step;
        #3 rst = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_wb_v", wb_v_o, 0);
        chk("arst_wb_sel", wb_sel_o, 0);
        chk("arst_wb_rd", wb_rd_num_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_ex_go", ex_go_o, 0);
        chk("arst_start", mdu_start_o, 0);
        step; step;
        rst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step;
            seen |= wb_v_o | busy_o;
        end
        chk("arst_no_wb", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
